// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry skid register stage with registered in_ready and flush
module pipe_skid_reg #(
  parameter int                   DATA_BITS   = 32,
  parameter logic [DATA_BITS-1:0] RESET_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic [1:0]           occupancy
);

  // State encoding doubles as the entry count driven on occupancy.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [DATA_BITS-1:0] r_main;
  logic [DATA_BITS-1:0] r_skid;

  // Handshake FSM: main register feeds the output, skid catches the one beat
  // that arrives while the output is stalled; in_ready is registered so that
  // out_ready never reaches it combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main      <= RESET_VALUE;
      r_skid      <= RESET_VALUE;
    end else if (flush) begin
      // Drop every held entry; data registers keep their contents.
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (in_valid) begin
            r_main      <= in_data;
            r_state     <= ST_BUSY;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (in_valid && out_ready) begin
            // Pass-through: replace the departing entry with the new one.
            r_main <= in_data;
          end else if (in_valid) begin
            // Output stalled: park the new beat in the skid register.
            r_skid     <= in_data;
            r_state    <= ST_FULL;
            r_in_ready <= 1'b0;
          end else if (out_ready) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          // Upstream is held off here; only a drain can change anything.
          if (out_ready) begin
            r_main     <= r_skid;
            r_state    <= ST_BUSY;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign occupancy = r_state;

endmodule
